// File: rtl/gpio_reg_bus_master.sv
// GPIO/ADC register bus initiator: command FIFO feeding a strobe
// sequencer, with one outstanding transaction and a registered response.
module gpio_reg_bus_master #(
  parameter int AddrWidth    = 16,
  parameter int BusWidth     = 32,
  parameter int FifoDepth    = 4,
  parameter int StrobeCycles = 2,
  parameter int ReadLatency  = 5,
  parameter int GapCycles    = 2
) (
  input  logic                 reg_clk,
  input  logic                 reset_in,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [AddrWidth-1:0] cmd_addr,
  input  logic [BusWidth-1:0]  cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_write,
  output logic [BusWidth-1:0]  rsp_rdata,
  output logic                 chip_sel,
  output logic                 write_reg,
  output logic                 read_reg,
  output logic [AddrWidth-3:0] busaddress,
  output logic [BusWidth-1:0]  busdata_in,
  input  logic [BusWidth-1:0]  busdata_to_cpu,
  output logic                 busy
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int CntW = PtrW + 1;

  typedef struct packed {
    logic                 wr;
    logic [AddrWidth-3:0] addr;
    logic [BusWidth-1:0]  data;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, WAIT, RESP, GAP
  } state_t;

  cmd_t            mem_q [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            empty, full, push, pop;
  cmd_t            head, cmd_in;

  state_t               state_q;
  logic [3:0]           cnt_q;
  logic                 rw_q, cs_q, wr_q, rd_q;
  logic [AddrWidth-3:0] addr_q;
  logic [BusWidth-1:0]  data_q, rdata_q;
  logic                 rsp_valid_q, rsp_write_q;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cmd_addr[1:0];

  assign empty  = (count_q == '0);
  assign full   = (count_q == CntW'(FifoDepth));
  assign push   = cmd_valid && !full;
  assign pop    = (state_q == IDLE) && !empty;
  assign head   = mem_q[rd_ptr_q];
  assign cmd_in = '{wr: cmd_write,
                    addr: cmd_addr[AddrWidth-1:2],
                    data: cmd_wdata};

  always_ff @(posedge reg_clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  // Counters load with values >= 1 and only step down while above 1.
  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rw_q        <= 1'b0;
      cs_q        <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            rw_q    <= head.wr;
            addr_q  <= head.addr;
            data_q  <= head.data;
            cs_q    <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          wr_q    <= rw_q;
          rd_q    <= !rw_q;
          cnt_q   <= 4'(StrobeCycles);
          state_q <= STROBE;
        end
        STROBE: begin
          if (cnt_q == 4'd1) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            cnt_q   <= rw_q ? 4'd1 : 4'(ReadLatency);
            state_q <= WAIT;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd1) begin
            rdata_q     <= rw_q ? '0 : busdata_to_cpu;
            rsp_write_q <= rw_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cs_q        <= 1'b0;
            cnt_q       <= 4'(GapCycles);
            state_q     <= GAP;
          end
        end
        GAP: begin
          if (cnt_q <= 4'd1) state_q <= IDLE;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = !full;
  assign busy       = (state_q != IDLE) || !empty;
  assign chip_sel   = cs_q;
  assign write_reg  = wr_q;
  assign read_reg   = rd_q;
  assign busaddress = addr_q;
  assign busdata_in = data_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_write  = rsp_write_q;
  assign rsp_rdata  = rdata_q;

endmodule

// File: tb/tb_gpio_reg_bus_master.sv
// Directed bench for gpio_reg_bus_master: vector table plus
// backlog, reset and fast-parameter sequences.
module tb_gpio_reg_bus_master;

  logic        clk = 1'b0;
  logic        reset_in = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_write;
  logic [31:0] rsp_rdata, busdata_in, busdata_to_cpu;
  logic        chip_sel, write_reg, read_reg, busy;
  logic [13:0] busaddress;

  logic        f_cmd_valid = 1'b0, f_cmd_ready, f_cmd_write = 1'b0;
  logic [15:0] f_cmd_addr = '0;
  logic        f_rsp_valid, f_rsp_write;
  logic [31:0] f_rsp_rdata, f_busdata_in;
  logic        f_chip_sel, f_write_reg, f_read_reg, f_busy;
  logic [13:0] f_busaddress;

  logic [31:0] slave_val = '0;
  logic [3:0]  fc = 4'd15;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gpio_reg_bus_master u_dut (
    .reg_clk(clk), .reset_in(reset_in),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .chip_sel(chip_sel), .write_reg(write_reg),
    .read_reg(read_reg), .busaddress(busaddress),
    .busdata_in(busdata_in),
    .busdata_to_cpu(busdata_to_cpu), .busy(busy)
  );

  gpio_reg_bus_master #(
    .StrobeCycles(1), .ReadLatency(1), .GapCycles(1)
  ) u_fast (
    .reg_clk(clk), .reset_in(reset_in),
    .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready),
    .cmd_write(f_cmd_write), .cmd_addr(f_cmd_addr),
    .cmd_wdata(32'h0),
    .rsp_valid(f_rsp_valid), .rsp_ready(1'b1),
    .rsp_write(f_rsp_write), .rsp_rdata(f_rsp_rdata),
    .chip_sel(f_chip_sel), .write_reg(f_write_reg),
    .read_reg(f_read_reg), .busaddress(f_busaddress),
    .busdata_in(f_busdata_in),
    .busdata_to_cpu(32'h0F0F0F0F), .busy(f_busy)
  );

  // Slave only drives valid data from the 3rd cycle after read_reg falls.
  always @(posedge clk) begin
    if (read_reg) fc <= 4'd0;
    else if (fc != 4'd15) fc <= fc + 4'd1;
  end
  assign busdata_to_cpu = (fc >= 4'd2 && fc != 4'd15) ? slave_val : 32'hBAD0BAD0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] sval;
    logic [13:0] e_ba;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vt[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cs_k, st_first, st_cnt, ot_cnt, rv_first, rv_cnt;
    logic        c_wr;
    logic [31:0] c_rd, c_bd;
    logic [13:0] c_ba;
    int nresp, runlen, act, gotst;
    int rise[3];
    int nrise;
    logic prev_cs;

    vt[0] = '{1'b1, 16'h1100, 32'h00ABCDEF, 32'h0, 14'h0440, 32'h0};
    vt[1] = '{1'b0, 16'h1004, 32'h11111111, 32'h00123456, 14'h0401, 32'h00123456};
    vt[2] = '{1'b1, 16'h1303, 32'hCAFEF00D, 32'h0, 14'h04C0, 32'h0};
    vt[3] = '{1'b0, 16'hFFFC, 32'h22222222, 32'hFFFFFFFF, 14'h3FFF, 32'hFFFFFFFF};
    vt[4] = '{1'b0, 16'h0000, 32'h33333333, 32'hA5A5A5A5, 14'h0000, 32'hA5A5A5A5};
    vt[5] = '{1'b1, 16'h0002, 32'h00000000, 32'h0, 14'h0000, 32'h0};

    // Reset values
    @(posedge clk); #2;
    chk("rst_chip_sel", 32'(chip_sel), 0);
    chk("rst_write_reg", 32'(write_reg), 0);
    chk("rst_read_reg", 32'(read_reg), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_write", 32'(rsp_write), 0);
    chk("rst_busaddress", 32'(busaddress), 0);
    chk("rst_busdata_in", busdata_in, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk); reset_in = 1'b0;
    repeat (2) @(negedge clk);

    // Single-transaction vectors, rsp_ready held high
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = vt[i].wr;
      cmd_addr = vt[i].addr; cmd_wdata = vt[i].wdata;
      slave_val = vt[i].sval;
      @(posedge clk); #1 cmd_valid = 1'b0;
      cs_k = -1; st_first = -1; st_cnt = 0; ot_cnt = 0;
      rv_first = -1; rv_cnt = 0;
      c_wr = 1'bx; c_rd = 'x; c_ba = 'x; c_bd = 'x;
      for (int k = 1; k <= 30; k++) begin
        @(posedge clk); #1;
        if (cs_k < 0 && chip_sel) cs_k = k;
        if (vt[i].wr ? write_reg : read_reg) begin
          if (st_first < 0) st_first = k;
          st_cnt++;
        end
        if (vt[i].wr ? read_reg : write_reg) ot_cnt++;
        if (rsp_valid) begin
          if (rv_first < 0) begin
            rv_first = k; c_wr = rsp_write; c_rd = rsp_rdata;
            c_ba = busaddress; c_bd = busdata_in;
          end
          rv_cnt++;
        end
      end
      chk($sformatf("v%0d_cs_edge", i), 32'(cs_k), 1);
      chk($sformatf("v%0d_strobe_edge", i), 32'(st_first), 2);
      chk($sformatf("v%0d_strobe_len", i), 32'(st_cnt), 2);
      chk($sformatf("v%0d_other_strobe", i), 32'(ot_cnt), 0);
      chk($sformatf("v%0d_rsp_edge", i), 32'(rv_first), vt[i].wr ? 5 : 9);
      chk($sformatf("v%0d_rsp_len", i), 32'(rv_cnt), 1);
      chk($sformatf("v%0d_rsp_write", i), 32'(c_wr), 32'(vt[i].wr));
      chk($sformatf("v%0d_rsp_rdata", i), c_rd, vt[i].e_rdata);
      chk($sformatf("v%0d_busaddress", i), 32'(c_ba), 32'(vt[i].e_ba));
      chk($sformatf("v%0d_busdata_in", i), c_bd, vt[i].wdata);
      chk($sformatf("v%0d_idle_cs", i), 32'(chip_sel), 0);
      chk($sformatf("v%0d_hold_addr", i), 32'(busaddress), 32'(vt[i].e_ba));
    end

    // Backlog: 5 accepted with rsp_ready low, 6th stalls
    rsp_ready = 1'b0;
    slave_val = 32'h00C0FFEE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bl_ready%0d", i), 32'(cmd_ready), 1);
      cmd_valid = 1'b1; cmd_write = (i % 2 == 0);
      cmd_addr = 16'(16 * (i + 1)); cmd_wdata = 32'(i);
    end
    @(negedge clk);
    cmd_write = 1'b1; cmd_addr = 16'h0FF0;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("bl_full%0d", j), 32'(cmd_ready), 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("bl_stall_valid", 32'(rsp_valid), 1);
    chk("bl_busy", 32'(busy), 1);
    rsp_ready = 1'b1;
    nresp = 0; runlen = 0;
    for (int k = 0; k < 120; k++) begin
      if (rsp_valid) begin
        if (nresp < 5) begin
          chk($sformatf("bl_addr%0d", nresp), 32'(busaddress),
              32'(4 * (nresp + 1)));
          chk($sformatf("bl_wr%0d", nresp), 32'(rsp_write),
              (nresp % 2 == 0) ? 1 : 0);
          chk($sformatf("bl_rdata%0d", nresp), rsp_rdata,
              (nresp % 2 == 0) ? 32'h0 : 32'h00C0FFEE);
        end
        nresp++;
      end
      if (!chip_sel) runlen++;
      else begin
        if (runlen > 0 && nresp > 0)
          chk($sformatf("bl_gap%0d", nresp), 32'(runlen), 3);
        runlen = 0;
      end
      @(negedge clk);
    end
    chk("bl_nresp", 32'(nresp), 5);

    // Fast parameters: StrobeCycles=ReadLatency=GapCycles=1
    nrise = 0; rv_first = -1; c_rd = 'x; prev_cs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      f_cmd_valid = 1'b1; f_cmd_write = 1'b0;
      f_cmd_addr = 16'(16'h0200 + 4 * i);
    end
    @(posedge clk); #1 f_cmd_valid = 1'b0;
    prev_cs = f_chip_sel;
    // Accept edge of first read was two edges ago; its pop already seen.
    rise[0] = prev_cs ? 1 : -1;
    nrise = 1;
    for (int k = 3; k <= 30; k++) begin
      @(posedge clk); #1;
      if (f_chip_sel && !prev_cs && nrise < 3) begin
        rise[nrise] = k; nrise++;
      end
      if (f_rsp_valid && rv_first < 0) begin
        rv_first = k; c_rd = f_rsp_rdata;
      end
      prev_cs = f_chip_sel;
    end
    chk("fast_first_pop", 32'(rise[0]), 1);
    chk("fast_rsp_edge", 32'(rv_first), 4);
    chk("fast_rdata", c_rd, 32'h0F0F0F0F);
    chk("fast_pop2", 32'(nrise > 1 ? rise[1] : -1), 7);
    chk("fast_pop3", 32'(nrise > 2 ? rise[2] : -1), 13);

    // Reset during a read strobe with two commands queued
    slave_val = 32'h12121212;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = (i != 0);
      cmd_addr = 16'(16'h2000 + 4 * i); cmd_wdata = 32'h5;
    end
    @(posedge clk); #2 cmd_valid = 1'b0;
    gotst = 0;
    for (int k = 0; k < 10; k++) begin
      if (read_reg) begin gotst = 1; break; end
      @(posedge clk); #2;
    end
    chk("rr_strobe_seen", 32'(gotst), 1);
    reset_in = 1'b1;
    #1;
    chk("rr_read_reg", 32'(read_reg), 0);
    chk("rr_chip_sel", 32'(chip_sel), 0);
    @(negedge clk); @(negedge clk);
    reset_in = 1'b0;
    chk("rr_busy", 32'(busy), 0);
    chk("rr_cmd_ready", 32'(cmd_ready), 1);
    chk("rr_rsp_valid", 32'(rsp_valid), 0);
    act = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (chip_sel || read_reg || write_reg || rsp_valid || busy) act++;
    end
    chk("rr_no_activity", 32'(act), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gpio_reg_bus_master.md
# gpio_reg_bus_master

Bus initiator for the GPIO/ADC register bus on `reg_clk`. It accepts read/write commands from a host-side bridge through a small command FIFO and drives the `chip_sel`/`write_reg`/`read_reg`/`busaddress`/`busdata_in` strobes with the pipeline timing the GPIO address decoder requires. It samples `busdata_to_cpu` after a fixed latency and returns each result on a valid/ready response channel.

## Interface
- `AddrWidth`, 16, byte address width; the bus carries bits `[AddrWidth-1:2]`.
- `BusWidth`, 32, data width.
- `FifoDepth`, 4, command FIFO entries; power of 2, 2..16.
- `StrobeCycles`, 2, cycles `write_reg`/`read_reg` stay high; 1..15.
- `ReadLatency`, 5, cycles from strobe deassertion to read-data sample; 1..15.
- `GapCycles`, 2, idle cycles with `chip_sel` low between transactions; 1..15.

Ports:
- `reg_clk`  in  1  clock; all logic on its rising edge.
- `reset_in`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  AddrWidth  byte address; bits `[1:0]` are ignored.
- `cmd_wdata`  in  BusWidth  write data.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed.
- `rsp_write`  out  1  response belongs to a write.
- `rsp_rdata`  out  BusWidth  read data; 0 for writes.
- `chip_sel`  out  1  bus select.
- `write_reg`  out  1  write strobe.
- `read_reg`  out  1  read strobe.
- `busaddress`  out  AddrWidth-2  word address (`cmd_addr[AddrWidth-1:2]`).
- `busdata_in`  out  BusWidth  write data to the slave.
- `busdata_to_cpu`  in  BusWidth  read data from the slave.
- `busy`  out  1  FSM not in IDLE, or FIFO not empty.

## Operation
- Command FIFO:
  - Push when `cmd_valid && cmd_ready`.
  - `cmd_ready = !full`. A push while full is impossible.
  - A simultaneous push and pop on a full FIFO is not a case, because `cmd_ready` is already low.
  - A push into an empty FIFO is poppable on the next edge.
  - Pointers wrap modulo `FifoDepth`. Keep `count` in log2(FifoDepth)+1 bits.
- FSM states: IDLE, SETUP, STROBE, WAIT, RESP, GAP.
  - IDLE: when the FIFO is non-empty, pop and latch addr/data/rw into the bus output registers, assert `chip_sel`, go to SETUP.
  - SETUP: one cycle with addr, data and `chip_sel` stable and strobes low. Go to STROBE and load counter = StrobeCycles.
  - STROBE: `write_reg` (write) or `read_reg` (read) is high. Decrement the counter; at 1, go to WAIT with counter = ReadLatency for reads, or 1 for writes.
  - WAIT: strobes low; addr, data and `chip_sel` held. Decrement the counter. At 1:
    - read: `rsp_rdata <= busdata_to_cpu`;
    - write: `rsp_rdata <= 0`;
    - in both cases `rsp_write <= rw`, `rsp_valid <= 1`, go to RESP.
  - RESP: hold all bus outputs. When `rsp_ready` is high, clear `rsp_valid`, drop `chip_sel`, go to GAP with counter = GapCycles.
  - GAP: `chip_sel` low, strobes low. Decrement the counter; at 1, go to IDLE.
- Transactions never overlap; at most one is outstanding.
- `busaddress` and `busdata_in` keep their last values after a transaction.
- Counters are 4 bits and never underflow.

## Timing
- All outputs are registered.
- Reset values:
  - `chip_sel`, `write_reg`, `read_reg`, `rsp_valid`, `rsp_write` = 0.
  - `busaddress`, `busdata_in`, `rsp_rdata` = 0.
  - FIFO empty, so `cmd_ready` = 1 and `busy` = 0.
  - FSM in IDLE.
- Reset asserted mid-transaction: strobes and `chip_sel` drop asynchronously. FIFO contents and any pending response are discarded.
- Command accepted at edge E0, FIFO empty, FSM idle:
  - E1: pop, `chip_sel` high.
  - E2: strobe high.
  - E(2+S): strobe low.
  - Read: `rsp_valid` high after E(2+S+ReadLatency).
  - Write: `rsp_valid` high after E(3+S).
  - S = StrobeCycles.
- With `rsp_ready` held high, `rsp_valid` is high for exactly one cycle.
- Next command pop: GapCycles cycles after the `rsp_valid && rsp_ready` edge, then one more edge in IDLE.
- `rsp_ready` low stalls indefinitely in RESP. The FIFO keeps accepting commands until full.

## Test plan
- Defaults; write addr 0x1100, data 0x00ABCDEF -> `busaddress`=0x0440, `busdata_in`=0x00ABCDEF, `write_reg` high for exactly 2 cycles starting 2 edges after accept, `rsp_valid` with `rsp_write`=1, `rsp_rdata`=0.
- Read addr 0x1004, slave model drives 0x00123456 only from the 3rd cycle after `read_reg` falls -> `rsp_rdata`=0x00123456, `rsp_write`=0, `rsp_valid` 5 cycles after strobe fall.
- Push 5 commands back-to-back with `rsp_ready` held low -> `cmd_ready` low after 4 accepted (first already popped counts as freeing one, so 5th accepted, 6th stalls). Release `rsp_ready` -> 5 responses in order, each separated by ≥GapCycles+1 idle cycles with `chip_sel` low.
- Addr 0x1303 (unaligned) -> `busaddress`=0x04C0; low bits dropped.
- Assert `reset_in` during STROBE of a read with 2 entries queued -> `read_reg`/`chip_sel` low immediately, no `rsp_valid`, `busy`=0 and `cmd_ready`=1 after release, no further bus activity.
- StrobeCycles=1, ReadLatency=1, GapCycles=1 -> read completes with `rsp_valid` 4 edges after accept. Back-to-back reads pop every 6 cycles with `rsp_ready` tied high.
